nios2_dbg_ocimem_arbiter: RTL

Arbiter and sequencer for the Nios II on-chip debug memory (OCI RAM / debug register file). It shares one single-ported, one-cycle-read-latency memory port between two requesters. The first is the JTAG debug slave command path: `take_action_*` strobes plus `jdo`, already synchronised into `clk`. The second is the CPU-side Avalon-MM debug slave. Read results for JTAG are returned in `MonDReg` with a `monitor_ready` handshake.

---
 rtl/nios2_dbg_pkg.sv | 28 ++
 rtl/nios2_dbg_ocimem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared types and jdo field positions for the Nios II debug OCI memory arbiter.
package nios2_dbg_pkg;

  // Arbiter/sequencer states: one IDLE slot, then a grant state and an
  // optional read-wait state per requester.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_J_WR  = 3'd1,
    ST_J_RD  = 3'd2,
    ST_J_RDW = 3'd3,
    ST_C_WR  = 3'd4,
    ST_C_RD  = 3'd5,
    ST_C_RDW = 3'd6
  } arb_state_e;

  // Which requester received the most recent grant.
  typedef enum logic {
    GRANT_JTAG = 1'b0,
    GRANT_CPU  = 1'b1
  } grant_e;

  // Bit positions inside the 38-bit JTAG data word.
  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 2;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ERRCLR    = 35;

endpackage

// File: rtl/nios2_dbg_ocimem_arbiter.sv
// Shares the single-ported OCI debug memory between the JTAG command path and
// the CPU-side Avalon-MM debug slave. JTAG commands are captured into a
// one-deep command register guarded by monitor_ready; a round-robin FSM then
// sequences JTAG and CPU accesses onto the memory port.
//
// Handshakes: JTAG strobes are accepted only while monitor_ready is 1; a
// strobe arriving while it is 0 is dropped and raises the sticky
// monitor_error. The CPU holds avl_read/avl_write until a cycle in which
// avl_waitrequest is 0; that cycle completes the transfer (write committed,
// or avl_readdata valid).
module nios2_dbg_ocimem_arbiter
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [31:0]       avl_writedata,
  output logic              avl_waitrequest,
  output logic [31:0]       avl_readdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_data_q, cmd_data_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic              monitor_ready_q, monitor_ready_d;
  logic              monitor_error_q, monitor_error_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;

  logic jtag_strobe;
  logic cpu_req;
  logic grant_jtag;

  // jdo bits outside the address/data/error-clear fields carry nothing here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_ERRCLR+1], jdo[JDO_ADDR_LSB-1:0]};

  assign jtag_strobe = take_action_ocimem_b | take_no_action_ocimem_a;
  assign cpu_req     = avl_read | avl_write;

  // JTAG command capture, monitor handshake, error flag and read-result register.
  always_comb begin
    jtag_addr_d     = jtag_addr_q;
    cmd_addr_d      = cmd_addr_q;
    cmd_data_d      = cmd_data_q;
    cmd_rd_d        = cmd_rd_q;
    monitor_ready_d = monitor_ready_q;
    monitor_error_d = monitor_error_q;
    mon_dreg_d      = mon_dreg_q;

    if (take_action_ocimem_a) begin
      // Address load beats a simultaneous read/write, which counts as an overrun.
      jtag_addr_d = jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
      if (jdo[JDO_ERRCLR]) monitor_error_d = 1'b0;
      if (jtag_strobe)     monitor_error_d = 1'b1;
    end else if (jtag_strobe) begin
      if (monitor_ready_q) begin
        cmd_addr_d      = jtag_addr_q;
        cmd_data_d      = jdo[JDO_WDATA_LSB +: 32];
        cmd_rd_d        = take_no_action_ocimem_a & ~take_action_ocimem_b;
        jtag_addr_d     = jtag_addr_q + 1'b1;
        monitor_ready_d = 1'b0;
      end else begin
        monitor_error_d = 1'b1;
      end
    end

    // Completion: monitor_ready is 0 throughout these states, so no new
    // command can have been accepted in the same cycle.
    if (state_q == ST_J_WR) monitor_ready_d = 1'b1;
    if (state_q == ST_J_RDW) begin
      monitor_ready_d = 1'b1;
      mon_dreg_d      = mem_rdata;
    end
  end

  // Arbitration next-state and memory/Avalon outputs decoded from the state.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_jtag      = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    mem_wdata       = '0;
    avl_waitrequest = 1'b1;
    avl_readdata    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // In IDLE a cleared monitor_ready always means an ungranted command.
        grant_jtag = ~monitor_ready_q & (~cpu_req | (last_grant_q == GRANT_CPU));
        if (grant_jtag) begin
          state_d      = cmd_rd_q ? ST_J_RD : ST_J_WR;
          last_grant_d = GRANT_JTAG;
        end else if (cpu_req) begin
          state_d      = avl_write ? ST_C_WR : ST_C_RD;
          last_grant_d = GRANT_CPU;
        end
      end
      ST_J_WR: begin
        mem_we    = 1'b1;
        mem_addr  = cmd_addr_q;
        mem_wdata = cmd_data_q;
        state_d   = ST_IDLE;
      end
      ST_J_RD: begin
        mem_re   = 1'b1;
        mem_addr = cmd_addr_q;
        state_d  = ST_J_RDW;
      end
      ST_J_RDW: state_d = ST_IDLE;
      ST_C_WR: begin
        mem_we          = 1'b1;
        mem_addr        = avl_address;
        mem_wdata       = avl_writedata;
        avl_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      ST_C_RD: begin
        mem_re   = 1'b1;
        mem_addr = avl_address;
        state_d  = ST_C_RDW;
      end
      ST_C_RDW: begin
        avl_readdata    = mem_rdata;
        avl_waitrequest = 1'b0;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops every pending and in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= GRANT_CPU;
      jtag_addr_q     <= '0;
      cmd_addr_q      <= '0;
      cmd_data_q      <= '0;
      cmd_rd_q        <= 1'b0;
      monitor_ready_q <= 1'b1;
      monitor_error_q <= 1'b0;
      mon_dreg_q      <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      jtag_addr_q     <= jtag_addr_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_data_q      <= cmd_data_d;
      cmd_rd_q        <= cmd_rd_d;
      monitor_ready_q <= monitor_ready_d;
      monitor_error_q <= monitor_error_d;
      mon_dreg_q      <= mon_dreg_d;
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = monitor_ready_q;
  assign monitor_error = monitor_error_q;

endmodule
